dma_reg_arbiter: RTL and testbench

- Shares the single DMA register bus (wr_en, rd_en, addr, wdata, rdata) between NUM_REQ requesters, e.g. CPU config port and the descriptor loader.
- Round-robin arbitration, one transaction outstanding at a time.
- Per-requester valid/ready command handshake and a response pulse.
- Sits between the requesters and the DMA register file.

---
 rtl/dma_reg_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dma_reg_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_reg_arbiter.sv
// Round-robin arbiter sharing one DMA register bus between NUM_REQ requesters.
// Optional address range check: define DMA_REG_ARB_ADDR_CHECK_EN.
module dma_reg_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'h100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      wr_en,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rdata,
  output logic                      busy
`ifdef DMA_REG_ARB_ADDR_CHECK_EN
  ,
  output logic [NUM_REQ-1:0]        rsp_err
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

`ifdef DMA_REG_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic [1:0]         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   own;
  logic               gnt_found;
  logic               take;
  logic               own_write;
  logic               own_err;
  logic [2:0]         cnt;

  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic               g_write;
  logic               g_err;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // Search upward from the pointer, wrapping, for the first valid requester.
  always_comb begin : p_arb
    int sum;
    logic [PTR_W-1:0] idx;
    sum       = 0;
    idx       = '0;
    gnt       = ptr;
    gnt_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PTR_W'(sum);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
  end

  assign take    = !rst && (state == S_IDLE) && gnt_found;
  assign g_addr  = addr_a[gnt];
  assign g_wdata = wdata_a[gnt];
  assign g_write = req_write[gnt];
  assign g_err   = ADDR_CHECK && (g_addr >= ADDR_LIMIT);
  assign ptr_nxt = (gnt == PTR_W'(NUM_REQ-1)) ? '0 : gnt + 1'b1;

  assign req_ready = take ? (NUM_REQ'(1) << gnt) : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      own       <= '0;
      own_write <= 1'b0;
      own_err   <= 1'b0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
`ifdef DMA_REG_ARB_ADDR_CHECK_EN
      rsp_err   <= '0;
`endif
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      rsp_valid <= '0;
`ifdef DMA_REG_ARB_ADDR_CHECK_EN
      rsp_err   <= '0;
`endif
      unique case (state)
        S_IDLE: begin
          if (take) begin
            own       <= gnt;
            own_write <= g_write;
            own_err   <= g_err;
            ptr       <= ptr_nxt;
            addr      <= g_addr;
            wdata     <= g_write ? g_wdata : '0;
            wr_en     <= g_write && !g_err;
            rd_en     <= !g_write && !g_err;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (own_write || own_err) begin
            rsp_valid <= NUM_REQ'(1) << own;
`ifdef DMA_REG_ARB_ADDR_CHECK_EN
            rsp_err   <= own_err ? (NUM_REQ'(1) << own) : '0;
`endif
            state     <= S_RESP;
          end else begin
            cnt   <= 3'(RD_LAT-1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // cnt hits zero in the cycle the register file presents rdata
          if (cnt == '0) begin
            rsp_rdata <= rdata;
            rsp_valid <= NUM_REQ'(1) << own;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_reg_arbiter.sv
// Directed + randomized bench for dma_reg_arbiter with a transaction-level
// reference model and register-file models for RD_LAT=1 and RD_LAT=3.
module tb_dma_reg_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD_LAT = 1;

`ifdef DMA_REG_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, wdata, rdata;
  logic [AW-1:0]   addr;
  logic            wr_en, rd_en, busy;

  logic [N-1:0]    r3_req_valid, r3_req_ready, r3_req_write, r3_rsp_valid;
  logic [N*AW-1:0] r3_req_addr;
  logic [N*DW-1:0] r3_req_wdata;
  logic [DW-1:0]   r3_rsp_rdata, r3_wdata, r3_rdata;
  logic [AW-1:0]   r3_addr;
  logic            r3_wr_en, r3_rd_en, r3_busy;

`ifdef DMA_REG_ARB_ADDR_CHECK_EN
  logic [N-1:0] rsp_err, r3_rsp_err;
`endif

  dma_reg_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy)
`ifdef DMA_REG_ARB_ADDR_CHECK_EN
    , .rsp_err(rsp_err)
`endif
  );

  dma_reg_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(r3_req_valid), .req_ready(r3_req_ready), .req_write(r3_req_write),
    .req_addr(r3_req_addr), .req_wdata(r3_req_wdata),
    .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata),
    .wr_en(r3_wr_en), .rd_en(r3_rd_en), .addr(r3_addr), .wdata(r3_wdata),
    .rdata(r3_rdata), .busy(r3_busy)
`ifdef DMA_REG_ARB_ADDR_CHECK_EN
    , .rsp_err(r3_rsp_err)
`endif
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 32'h20) return 32'h1234_5678;
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  // Register file with one-cycle read latency; junk outside the data cycle.
  logic [31:0] bus_mem [256];
  logic        rv;
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) bus_mem[i] <= init_val(i);
    end else if (wr_en) begin
      bus_mem[addr[7:0]] <= wdata;
    end
    rv   <= rd_en;
    rd_q <= bus_mem[addr[7:0]];
  end
  assign rdata = rv ? rd_q : 32'hBAD0_BAD0;

  // Three-cycle read latency register file for the second instance.
  logic [2:0]  v3;
  logic [31:0] d3 [3];
  always @(posedge clk) begin
    v3    <= {v3[1:0], r3_rd_en};
    d3[0] <= r3_addr ^ 32'hC0DE_0000;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign r3_rdata = v3[2] ? d3[2] : 32'h0BAD_F00D;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [256];
  int          ref_ptr;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ref_reset;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_ptr    = 0;
    last_rdata = '0;
  endtask

  function automatic int pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ref_ptr + k) % N;
      if (mask[i]) return i;
    end
    return 0;
  endfunction

  // One full transaction; leaves req_valid = after when back in IDLE.
  task automatic txn(input logic [N-1:0] mask, input logic [N-1:0] wr,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic [N-1:0] after);
    int g;
    logic w, err;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [N-1:0] one;
    g   = pick(mask);
    w   = wr[g];
    a   = (g == 0) ? a0 : a1;
    d   = (g == 0) ? d0 : d1;
    err = CHK && (a >= 32'h100);
    one = N'(1) << g;
    req_valid = mask;
    req_write = wr;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    check("ready_c0", req_ready, one);
    check("busy_c0", busy, 1'b0);
    ref_ptr = (g + 1) % N;
    tick;
    req_valid = after;
    #1;
    check("ready_c1", req_ready, '0);
    check("busy_c1", busy, 1'b1);
    check("wr_en_c1", wr_en, w && !err);
    check("rd_en_c1", rd_en, !w && !err);
    check("rsp_c1", rsp_valid, '0);
    if (!err) begin
      check("addr_c1", addr, a);
      check("wdata_c1", wdata, w ? d : '0);
    end
    if (w || err) begin
      tick;
      check("rsp_wr", rsp_valid, one);
      check("wr_en_c2", wr_en, 1'b0);
      check("rdata_hold", rsp_rdata, last_rdata);
`ifdef DMA_REG_ARB_ADDR_CHECK_EN
      check("rsp_err", rsp_err, err ? one : '0);
`endif
      if (!err) ref_mem[a[7:0]] = d;
    end else begin
      repeat (RD_LAT) begin
        tick;
        check("rsp_wait", rsp_valid, '0);
        check("rd_en_wait", rd_en, 1'b0);
      end
      tick;
      check("rsp_rd", rsp_valid, one);
      check("rsp_rdata", rsp_rdata, ref_mem[a[7:0]]);
`ifdef DMA_REG_ARB_ADDR_CHECK_EN
      check("rsp_err_rd", rsp_err, '0);
`endif
      last_rdata = ref_mem[a[7:0]];
    end
    tick;
    check("busy_end", busy, 1'b0);
    check("rsp_end", rsp_valid, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_write    = '0;
    req_addr     = '0;
    req_wdata    = '0;
    r3_req_valid = '0;
    r3_req_write = '0;
    r3_req_addr  = '0;
    r3_req_wdata = '0;
    ref_reset();
    repeat (2) tick;
    req_valid = 2'b11;
    #1;
    check("ready_in_rst", req_ready, '0);
    tick;
    check("rst_busy", busy, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_addr", addr, '0);
    check("rst_wdata", wdata, '0);
    check("rst_rsp", rsp_valid, '0);
    check("rst_rdata", rsp_rdata, '0);
    rst       = 1'b0;
    req_valid = '0;
    tick;
    check("idle_ready", req_ready, '0);
    check("idle_busy", busy, 1'b0);

    // Directed write from req0, then read from req1
    txn(2'b01, 2'b01, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0, 2'b00);
    txn(2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0, 2'b00);
    check("plan_rdata", rsp_rdata, 32'h1234_5678);

    // Both requesters continuously valid: rotation
    for (int k = 0; k < 4; k++)
      txn(2'b11, 2'($urandom), 32'h40 + 32'(k*4), 32'h80 + 32'(k*4),
          $urandom, $urandom, 2'b11);

    // Same requester re-requesting during RESP, then dropping before ready
    txn(2'b01, 2'b01, 32'h34, 32'h0, 32'h1111_2222, 32'h0, 2'b01);
    req_valid = '0;
    #1;
    check("drop_ready", req_ready, '0);
    tick;
    check("drop_busy", busy, 1'b0);
    check("drop_wr_en", wr_en, 1'b0);
    check("drop_rd_en", rd_en, 1'b0);

    // Reset during WAIT of a read
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr  = {32'h0, 32'h30};
    #1;
    check("rw_ready", req_ready, 2'b01 << pick(2'b01));
    tick;
    req_valid = '0;
    check("rw_rd_en", rd_en, 1'b1);
    tick;
    check("rw_busy", busy, 1'b1);
    rst       = 1'b1;
    req_valid = 2'b11;
    tick;
    check("rw_rsp", rsp_valid, '0);
    check("rw_busy0", busy, 1'b0);
    check("rw_rd_en0", rd_en, 1'b0);
    check("rw_addr0", addr, '0);
    check("rw_rdata0", rsp_rdata, '0);
    check("rw_ready0", req_ready, '0);
    rst = 1'b0;
    ref_reset();
    txn(2'b11, 2'b00, 32'h20, 32'h24, 32'h0, 32'h0, 2'b00);

    // Randomized traffic
    for (int k = 0; k < 24; k++)
      txn(2'($urandom_range(1, 3)), 2'($urandom),
          {24'h0, 6'($urandom), 2'b00}, {24'h0, 6'($urandom), 2'b00},
          $urandom, $urandom, 2'($urandom));
    txn(2'b11, 2'b00, 32'h10, 32'h34, 32'h0, 32'h0, 2'b00);

`ifdef DMA_REG_ARB_ADDR_CHECK_EN
    txn(2'b01, 2'b01, 32'h104, 32'h0, 32'hCAFE_0001, 32'h0, 2'b00);
    txn(2'b01, 2'b01, 32'hFC, 32'h0, 32'hCAFE_0002, 32'h0, 2'b00);
    txn(2'b10, 2'b00, 32'h0, 32'hFC, 32'h0, 32'h0, 2'b00);
`endif

    // RD_LAT=3 instance: read from req0
    req_valid       = '0;
    r3_req_valid    = 2'b01;
    r3_req_write    = 2'b00;
    r3_req_addr     = {32'h0, 32'h44};
    #1;
    check("r3_ready", r3_req_ready, 2'b01);
    tick;
    r3_req_valid = '0;
    check("r3_rd_en", r3_rd_en, 1'b1);
    check("r3_addr", r3_addr, 32'h44);
    for (int c = 2; c <= 4; c++) begin
      tick;
      check("r3_rsp_wait", r3_rsp_valid, '0);
    end
    tick;
    check("r3_rsp", r3_rsp_valid, 2'b01);
    check("r3_rdata", r3_rsp_rdata, 32'hC0DE_0044);
    tick;
    check("r3_busy", r3_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
